// File: rtl/cv32e40p_ft_recovery_ctrl.sv
// Recovery scheduler for a triplicated fault-tolerant unit: stalls the pipeline,
// clears and probates a broken replica, and disables replicas that keep failing.
module cv32e40p_ft_recovery_ctrl #(
   parameter int unsigned RECOVER_CYCLES   = 16,
   parameter int unsigned PROBATION_CYCLES = 256,
   parameter int unsigned MAX_RETRIES      = 2,
   parameter int unsigned CNT_W            = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       is_broken_i,
   input  logic             err_detected_i,
   input  logic             stall_ack_i,
   output logic             stall_req_o,
   output logic [2:0]       clear_broken_o,
   output logic [2:0]       set_broken_o,
   output logic             fatal_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] err_count_o
);

   localparam int unsigned WIN_MAX = (RECOVER_CYCLES > PROBATION_CYCLES) ? RECOVER_CYCLES
                                                                          : PROBATION_CYCLES;
   localparam int unsigned TW = $clog2(WIN_MAX);
   localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
   localparam logic [TW-1:0] RECOVER_LOAD   = TW'(RECOVER_CYCLES - 1);
   localparam logic [TW-1:0] PROBATION_LOAD = TW'(PROBATION_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT    = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {IDLE, REQ, RECOVER, CLEAR, PROBATION, FATAL} state_t;

   state_t               state, state_nx;
   logic [TW-1:0]        cnt, cnt_nx;
   logic [1:0]           target, target_nx;
   logic [2:0][RW-1:0]   retry, retry_nx;
   logic [RW-1:0]        retry_inc;
   logic [2:0]           set_broken_nx;
   logic [2:0]           bad;
   logic [2:0]           cand;
   logic                 fatal_cond;

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      target_nx     = target;
      retry_nx      = retry;
      set_broken_nx = set_broken_o;
      bad           = is_broken_i | set_broken_o;
      cand          = is_broken_i & ~set_broken_o;
      fatal_cond    = (bad[0] & bad[1]) | (bad[0] & bad[2]) | (bad[1] & bad[2]);
      retry_inc     = retry[target] + RW'(1);

      case (state)
         IDLE: begin
            if (cand != 3'b000) begin
               state_nx = REQ;
               if (cand[0])      target_nx = 2'd0;
               else if (cand[1]) target_nx = 2'd1;
               else              target_nx = 2'd2;
            end
         end
         REQ: begin
            if (stall_ack_i) begin
               state_nx = RECOVER;
               cnt_nx   = RECOVER_LOAD;
            end
         end
         RECOVER: begin
            if (cnt == '0) state_nx = CLEAR;
            else           cnt_nx   = cnt - TW'(1);
         end
         CLEAR: begin
            state_nx = PROBATION;
            cnt_nx   = PROBATION_LOAD;
         end
         PROBATION: begin
            // the first probation cycle still sees the pre-clear monitor flag
            if ((cnt != PROBATION_LOAD) && is_broken_i[target]) begin
               retry_nx[target] = retry_inc;
               if (retry_inc == RETRY_LIMIT) begin
                  set_broken_nx[target] = 1'b1;
                  state_nx              = IDLE;
               end else begin
                  state_nx = REQ;
               end
            end else if (cnt == '0) begin
               retry_nx[target] = '0;
               state_nx         = IDLE;
            end else begin
               cnt_nx = cnt - TW'(1);
            end
         end
         FATAL:   state_nx = FATAL;
         default: state_nx = IDLE;
      endcase

      // fatal overrides every transition above and freezes all bookkeeping
      if (fatal_cond) begin
         state_nx      = FATAL;
         cnt_nx        = cnt;
         target_nx     = target;
         retry_nx      = retry;
         set_broken_nx = set_broken_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         target         <= '0;
         retry          <= '0;
         stall_req_o    <= 1'b0;
         clear_broken_o <= '0;
         set_broken_o   <= '0;
         fatal_o        <= 1'b0;
         busy_o         <= 1'b0;
         err_count_o    <= '0;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         target         <= target_nx;
         retry          <= retry_nx;
         set_broken_o   <= set_broken_nx;
         stall_req_o    <= (state_nx == REQ) || (state_nx == RECOVER) || (state_nx == CLEAR);
         clear_broken_o <= (state_nx == CLEAR) ? (3'b001 << target_nx) : 3'b000;
         busy_o         <= (state_nx != IDLE) && (state_nx != FATAL);
         fatal_o        <= (state_nx == FATAL);
         if (err_detected_i && (err_count_o != '1))
            err_count_o <= err_count_o + CNT_W'(1);
      end
   end

endmodule

// File: doc/cv32e40p_ft_recovery_ctrl.md
# cv32e40p_ft_recovery_ctrl

Recovery scheduler for one triplicated fault-tolerant unit (e.g. the TMR compressed decoder). It watches the per-replica breakage flags and voter error pulses. When a replica is declared broken it requests a pipeline stall, holds it for a fixed recovery window, then clears the replica's breakage monitor and puts the replica on probation. A replica that keeps failing is permanently disabled, and losing two replicas raises a sticky fatal flag.

## Interface
- RECOVER_CYCLES, 16: stall-window length in cycles, ≥1
- PROBATION_CYCLES, 256: observation window after clear, ≥2
- MAX_RETRIES, 2: recovery attempts per replica before permanent disable, ≥1
- CNT_W, 16: error-counter width
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- is_broken_i  in  3  per-replica flag from the breakage monitors
- err_detected_i  in  1  OR of voter error-detected pulses
- stall_ack_i  in  1  pipeline has drained and is stalled
- stall_req_o  out  1  stall request to the controller
- clear_broken_o  out  3  one-cycle clear pulse to the selected replica's breakage monitor
- set_broken_o  out  3  permanent-disable mask, drives the unit's set_broken_i
- fatal_o  out  1  sticky: fewer than two usable replicas
- busy_o  out  1  FSM not in IDLE and not in FATAL
- err_count_o  out  CNT_W  saturating count of err_detected_i cycles

## Operation
- Bad replica: is_broken_i[k] | set_broken_o[k]. Fatal condition: two or more bad replicas.
- FSM states: IDLE, REQ, RECOVER, CLEAR, PROBATION, FATAL.
- IDLE: target = lowest k with is_broken_i[k]=1 and set_broken_o[k]=0. If a target exists, go to REQ; otherwise stay in IDLE.
- REQ: stall_req_o=1. Go to RECOVER on the first cycle stall_ack_i=1. There is no timeout.
- RECOVER: stall_req_o=1. Down-counter loaded with RECOVER_CYCLES-1 on entry. Go to CLEAR when the counter reads 0.
- CLEAR: stall_req_o=1 and clear_broken_o[target]=1 for exactly one cycle. Always go to PROBATION.
- PROBATION: stall_req_o=0. Counter loaded with PROBATION_CYCLES-1 on entry.
  - The first probation cycle ignores is_broken_i[target] (monitor clear latency).
  - On any later cycle, if is_broken_i[target]=1: increment retry[target].
    - New value equals MAX_RETRIES: set set_broken_o[target] and go to IDLE.
    - Otherwise go to REQ with the same target.
  - If the counter expires clean: retry[target]=0, go to IDLE.
- Fatal check runs in every state and has priority over every other transition.
  - Next state is FATAL and fatal_o=1.
  - stall_req_o, clear_broken_o and busy_o go to 0.
  - set_broken_o holds its value.
- FATAL exits only on rst.
- Breakage of a non-target replica during recovery does not preempt the current target. It is picked up in IDLE unless it triggers fatal.
- err_count_o increments once per cycle with err_detected_i=1, in every state, and saturates at 2^CNT_W-1.
- retry counters: one per replica, width $clog2(MAX_RETRIES+1).

## Timing
- All outputs are registered. Reset value: every output 0, FSM in IDLE, all counters 0, all retry counters 0, set_broken_o=000.
- Reset mid-operation: on the next edge the block is back in IDLE with everything zeroed, including set_broken_o and fatal_o. rst wins over every simultaneous event.
- Replica breaks at cycle t (first cycle is_broken_i=1 while in IDLE): stall_req_o=1 from t+1.
- Ack seen at cycle a: RECOVER spans a+1 .. a+RECOVER_CYCLES. clear_broken_o pulses at a+RECOVER_CYCLES+1. stall_req_o falls at a+RECOVER_CYCLES+2.
- Clean probation: PROBATION_CYCLES cycles, then IDLE. busy_o=0 on the following cycle.
- Fatal condition at cycle t: fatal_o=1 and stall_req_o=0 at t+1.
- err_detected_i at cycle t: err_count_o updated at t+1.

## Test plan
- Reset: hold rst 2 cycles with random inputs. All outputs must be 0; err_count_o=0.
- Single recovery: RECOVER_CYCLES=16, is_broken_i=010, ack 3 cycles after the request, monitor clears on the pulse.
  - clear_broken_o=010 exactly 16 cycles after the ack cycle + 1.
  - After 256 clean cycles busy_o=0 and set_broken_o=000.
- Retry exhaustion: MAX_RETRIES=2, replica 0 re-breaks on the 5th probation cycle each time.
  - Two full recovery sequences occur, then set_broken_o=001.
  - FSM returns to IDLE; no third clear pulse.
- Fatal: set_broken_o=001 already set, then is_broken_i=100 during REQ.
  - Next cycle fatal_o=1, stall_req_o=0.
  - fatal_o persists until rst; a later is_broken_i change has no effect.
- Counter saturation: CNT_W=4, 20 consecutive err_detected_i cycles. err_count_o stops at 15.
- Reset during RECOVER: assert rst in cycle 5 of RECOVER. Next cycle all outputs are 0 and there is no clear pulse.
